sram_bus_arbiter: RTL and testbench

- Shares one SRAM-like memory port between instruction fetch (F stage) and data access (M stage).
- Generates the i_stall and d_stall inputs consumed by the pipeline datapath.
- Holds each side's completed result until the whole pipeline advances, so nothing is re-fetched or re-written while the other side is still stalling.
- Sits between the datapath and the bus bridge/cache.

---
 rtl/sram_bus_arbiter_pkg.sv | 20 ++
 rtl/sram_bus_arbiter_side_hold.sv | 44 ++++
 rtl/sram_bus_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared definitions for the SRAM bus arbiter: FSM state encoding and the
// saturating increment used by the optional stall counters (ARB_PERF_CNT_EN).
package sram_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ArbIdle  = 3'd0,
    ArbDReq  = 3'd1,
    ArbDWait = 3'd2,
    ArbIReq  = 3'd3,
    ArbIWait = 3'd4
  } arb_state_e;

  localparam logic [31:0] StallCntMax = 32'hFFFF_FFFF;

  // Saturating +1 for 32-bit event counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == StallCntMax) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sram_bus_arbiter_side_hold.sv
// Per-side completion holder: keeps the done flag and the last read result
// until the whole pipeline advances. One instance each for fetch and data.
module sram_bus_arbiter_side_hold
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_i,
  input  logic              capture_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              advance_i,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic              done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Next state: a completion in the same edge as an advance keeps done set.
  always_comb begin
    done_d  = done_q;
    rdata_d = rdata_q;
    if (advance_i) done_d = 1'b0;
    if (set_i)     done_d = 1'b1;
    if (capture_i) rdata_d = rdata_i;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign done_o  = done_q;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data access and
// produces the pipeline's i_stall/d_stall. Data has fixed priority; a granted
// transaction always runs to completion. Optional stall counters are added
// when ARB_PERF_CNT_EN is defined.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_en,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                i_stall,
  input  logic                data_en,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                d_stall,
  input  logic                longest_stall,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]         i_stall_cnt,
  output logic [31:0]         d_stall_cnt
`endif
);

  localparam int unsigned StrbW = DATA_W / 8;

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0]  wstrb_q, wstrb_d;

  logic i_done, d_done;
  logic i_pend, d_pend;
  logic i_set, i_cap, d_set, d_cap;
  logic d_is_read;

  assign i_pend    = inst_en & ~i_done;
  assign d_pend    = data_en & ~d_done;
  assign i_stall   = i_pend;
  assign d_stall   = d_pend;
  assign d_is_read = ~|wstrb_q;

  // Next-state, request controls and completion strobes.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    mem_req = 1'b0;
    i_set   = 1'b0;
    i_cap   = 1'b0;
    d_set   = 1'b0;
    d_cap   = 1'b0;
    unique case (state_q)
      ArbIdle: begin
        if (d_pend) begin
          state_d = ArbDReq;
          addr_d  = data_addr;
          wdata_d = data_wdata;
          wstrb_d = data_wen;
        end else if (i_pend) begin
          state_d = ArbIReq;
          addr_d  = inst_addr;
          wdata_d = '0;
          wstrb_d = '0;
        end
      end
      ArbDReq: begin
        mem_req = 1'b1;
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            state_d = ArbIdle;
            d_set   = 1'b1;
            d_cap   = d_is_read;
          end else begin
            state_d = ArbDWait;
          end
        end
      end
      ArbDWait: begin
        if (mem_data_ok) begin
          state_d = ArbIdle;
          d_set   = 1'b1;
          d_cap   = d_is_read;
        end
      end
      ArbIReq: begin
        mem_req = 1'b1;
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            state_d = ArbIdle;
            i_set   = 1'b1;
            i_cap   = 1'b1;
          end else begin
            state_d = ArbIWait;
          end
        end
      end
      ArbIWait: begin
        if (mem_data_ok) begin
          state_d = ArbIdle;
          i_set   = 1'b1;
          i_cap   = 1'b1;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ArbIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign mem_wr    = mem_req & ~d_is_read;
  assign mem_wstrb = wstrb_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  sram_bus_arbiter_side_hold #(
    .DATA_W (DATA_W)
  ) u_i_hold (
    .clk       (clk),
    .rst       (rst),
    .set_i     (i_set),
    .capture_i (i_cap),
    .rdata_i   (mem_rdata),
    .advance_i (~longest_stall),
    .done_o    (i_done),
    .rdata_o   (inst_rdata)
  );

  sram_bus_arbiter_side_hold #(
    .DATA_W (DATA_W)
  ) u_d_hold (
    .clk       (clk),
    .rst       (rst),
    .set_i     (d_set),
    .capture_i (d_cap),
    .rdata_i   (mem_rdata),
    .advance_i (~longest_stall),
    .done_o    (d_done),
    .rdata_o   (data_rdata)
  );

`ifdef ARB_PERF_CNT_EN
  logic [31:0] i_cnt_q, d_cnt_q;

  // Saturating counts of cycles spent stalled on each side.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
    end else begin
      if (i_stall) i_cnt_q <= sat_inc(i_cnt_q);
      if (d_stall) d_cnt_q <= sat_inc(d_cnt_q);
    end
  end

  assign i_stall_cnt = i_cnt_q;
  assign d_stall_cnt = d_cnt_q;
`endif

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: directed scenarios then random
// steps against a transaction-level model (expected bus order, fields,
// stall durations from slave latencies, and returned data).
module tb_sram_bus_arbiter;

  typedef struct {
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk;
  logic        rst;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        i_stall;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        d_stall;
  logic        longest_stall;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] i_stall_cnt;
  logic [31:0] d_stall_cnt;
`endif

  logic hold;
  assign longest_stall = i_stall | d_stall | hold;

  sram_bus_arbiter #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_en       (inst_en),
    .inst_addr     (inst_addr),
    .inst_rdata    (inst_rdata),
    .i_stall       (i_stall),
    .data_en       (data_en),
    .data_wen      (data_wen),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_rdata    (data_rdata),
    .d_stall       (d_stall),
    .longest_stall (longest_stall),
    .mem_req       (mem_req),
    .mem_wr        (mem_wr),
    .mem_wstrb     (mem_wstrb),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_addr_ok   (mem_addr_ok),
    .mem_data_ok   (mem_data_ok),
    .mem_rdata     (mem_rdata)
`ifdef ARB_PERF_CNT_EN
    ,
    .i_stall_cnt   (i_stall_cnt),
    .d_stall_cnt   (d_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_irdata, exp_drdata;
  int          exp_icnt, exp_dcnt;

  // Slave configuration and bookkeeping.
  int   a_lat, d_lat;
  int   areq_cnt, wait_cnt;
  logic out_busy, acc_r, dok_r;
  logic [31:0] out_addr;
  txn_t cur;
  txn_t log_q[$];

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2408_0001;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234 ^ (a * 32'd7);
  endfunction

  // Bus slave: decides addr_ok/data_ok on the falling edge, retiring what the
  // DUT saw at the previous rising edge first.
  always @(negedge clk) begin
    if (!rst) begin
      out_busy    = 1'b0;
      areq_cnt    = 0;
      acc_r       = 1'b0;
      dok_r       = 1'b0;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata   = 32'h0;
    end else begin
      if (acc_r) begin
        log_q.push_back(cur);
        areq_cnt = 0;
        if (!dok_r) begin
          out_busy = 1'b1;
          wait_cnt = d_lat - 1;
          out_addr = cur.addr;
        end
      end else if (dok_r) begin
        out_busy = 1'b0;
      end
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata   = $urandom;
      if (out_busy) begin
        if (wait_cnt <= 0) begin
          mem_data_ok = 1'b1;
          mem_rdata   = rd_val(out_addr);
        end else begin
          wait_cnt--;
        end
      end else if (mem_req) begin
        if (areq_cnt >= a_lat) begin
          mem_addr_ok = 1'b1;
          cur = '{mem_wr, mem_wstrb, mem_addr, mem_wdata};
          if (d_lat == 0) begin
            mem_data_ok = 1'b1;
            mem_rdata   = rd_val(mem_addr);
          end
        end else begin
          areq_cnt++;
        end
      end
      acc_r = mem_addr_ok;
      dok_r = mem_data_ok;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One pipeline step: present requests, let the DUT finish, optionally hold
  // the pipeline, advance once, then check the bus log against the model.
  task automatic step(input logic ien, input logic [31:0] ia, input logic den,
                      input logic [3:0] dwen, input logic [31:0] da,
                      input logic [31:0] dwd, input int ddly, input int hold_cyc);
    int   ic, dc, lat, exp_ic, exp_dc, n_exp, di, fi;
    logic done_ok;
    txn_t t;
    log_q.delete();
    lat        = 2 + a_lat + d_lat;
    inst_en    = ien;
    inst_addr  = ia;
    data_wen   = dwen;
    data_addr  = da;
    data_wdata = dwd;
    data_en    = den && (ddly == 0);
    ic = 0;
    dc = 0;
    done_ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (den && c == ddly) data_en = 1'b1;
      #1;
      if (i_stall) ic++;
      if (d_stall) dc++;
      if (c >= ddly && !i_stall && !d_stall) begin
        done_ok = 1'b1;
        break;
      end
      tick();
    end
    chk("step_completes", 32'(done_ok), 32'd1);
    if (!done_ok) begin
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "step did not complete");
    end
    if (ien && den) begin
      if (ddly == 0) begin
        exp_dc = lat;
        exp_ic = 2 * lat;
      end else begin
        exp_ic = lat;
        exp_dc = 2 * lat - ddly;
      end
    end else begin
      exp_ic = ien ? lat : 0;
      exp_dc = den ? lat : 0;
    end
    chk("i_stall_cycles", 32'(ic), 32'(exp_ic));
    chk("d_stall_cycles", 32'(dc), 32'(exp_dc));
    exp_icnt += exp_ic;
    exp_dcnt += exp_dc;
    if (ien) exp_irdata = rd_val(ia);
    if (den && dwen == 4'b0) exp_drdata = rd_val(da);
    chk("inst_rdata", inst_rdata, exp_irdata);
    chk("data_rdata", data_rdata, exp_drdata);
    if (hold_cyc > 0) hold = 1'b1;
    for (int h = 0; h < hold_cyc; h++) begin
      tick();
      chk("hold_i_stall", 32'(i_stall), 32'd0);
      chk("hold_d_stall", 32'(d_stall), 32'd0);
      chk("hold_no_req", 32'(mem_req), 32'd0);
      chk("hold_data_rdata", data_rdata, exp_drdata);
    end
    hold = 1'b0;
    tick();
    inst_en = 1'b0;
    data_en = 1'b0;
    n_exp = int'(ien) + int'(den);
    chk("txn_count", 32'(log_q.size()), 32'(n_exp));
    if (log_q.size() == n_exp) begin
      di = (ien && den && ddly > 0) ? 1 : 0;
      fi = (ien && den && ddly == 0) ? 1 : 0;
      if (den) begin
        t = log_q[di];
        chk("d_txn_wr", 32'(t.wr), 32'(|dwen));
        chk("d_txn_wstrb", 32'(t.wstrb), 32'(dwen));
        chk("d_txn_addr", t.addr, da);
        if (|dwen) chk("d_txn_wdata", t.wdata, dwd);
      end
      if (ien) begin
        t = log_q[fi];
        chk("i_txn_wr", 32'(t.wr), 32'd0);
        chk("i_txn_wstrb", 32'(t.wstrb), 32'd0);
        chk("i_txn_addr", t.addr, ia);
      end
    end
  endtask

  initial begin
    logic        rien, rden;
    logic [3:0]  rwen;
    int          rdly;
    inst_en    = 1'b0;
    inst_addr  = 32'h0;
    data_en    = 1'b0;
    data_wen   = 4'h0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    hold       = 1'b0;
    a_lat      = 0;
    d_lat      = 1;
    exp_irdata = 32'h0;
    exp_drdata = 32'h0;
    exp_icnt   = 0;
    exp_dcnt   = 0;
    rst        = 1'b1;
    #2 rst = 1'b0;
    #1;
    // Asynchronous reset state, before any clock edge.
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_inst_rdata", inst_rdata, 32'h0);
    chk("rst_data_rdata", data_rdata, 32'h0);
    chk("rst_i_stall", 32'(i_stall), 32'd0);
    chk("rst_d_stall", 32'(d_stall), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Fetch only: addr_ok in the first request cycle, data_ok two cycles later.
    a_lat = 0;
    d_lat = 2;
    step(1'b1, 32'hBFC0_0000, 1'b0, 4'h0, 32'h0, 32'h0, 0, 0);
    chk("fetch_boot_word", inst_rdata, 32'h2408_0001);

    // Fetch and store together: store first, no repeat while held.
    a_lat = 1;
    d_lat = 1;
    step(1'b1, 32'hBFC0_0004, 1'b1, 4'b0011, 32'h0000_1000, 32'hCAFE_F00D, 0, 3);

    // Load completes, then the pipeline stays stalled for 10 cycles.
    a_lat = 0;
    d_lat = 2;
    step(1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_2000, 32'h0, 0, 10);

    // addr_ok and data_ok together.
    a_lat = 0;
    d_lat = 0;
    step(1'b1, 32'h8000_0010, 1'b1, 4'h0, 32'h0000_3000, 32'h0, 0, 0);

    // Random steps; a late data request arrives while a fetch is in flight.
    for (int n = 0; n < 60; n++) begin
      a_lat = int'($urandom_range(0, 3));
      d_lat = int'($urandom_range(0, 3));
      rien  = 1'($urandom_range(0, 1));
      rden  = 1'($urandom_range(0, 1));
      rdly  = (rien && rden) ? int'($urandom_range(0, 1)) : 0;
      rwen  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      step(rien, $urandom & 32'hFFFF_FFFC, rden, rwen, $urandom & 32'hFFFF_FFFC,
           $urandom, rdly, int'($urandom_range(0, 2)));
    end

    // Reset while a load waits for data.
    a_lat = 0;
    d_lat = 3;
    data_en   = 1'b1;
    data_wen  = 4'h0;
    data_addr = 32'h0000_4000;
    tick();
    tick();
    chk("pre_rst_mem_addr", mem_addr, 32'h0000_4000);
    chk("pre_rst_d_stall", 32'(d_stall), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_mem_wr", 32'(mem_wr), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    chk("midrst_mem_wdata", mem_wdata, 32'h0);
    chk("midrst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("midrst_inst_rdata", inst_rdata, 32'h0);
    chk("midrst_data_rdata", data_rdata, 32'h0);
    chk("midrst_d_stall_pend", 32'(d_stall), 32'd1);
    data_en    = 1'b0;
    exp_irdata = 32'h0;
    exp_drdata = 32'h0;
    exp_icnt   = 0;
    exp_dcnt   = 0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // 7-cycle fetch stall, then 3-cycle data stall.
    a_lat = 2;
    d_lat = 3;
    step(1'b1, 32'h0000_0100, 1'b0, 4'h0, 32'h0, 32'h0, 0, 0);
    a_lat = 1;
    d_lat = 0;
    step(1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_0200, 32'h0, 0, 0);
`ifdef ARB_PERF_CNT_EN
    chk("i_stall_cnt", i_stall_cnt, 32'd7);
    chk("d_stall_cnt", d_stall_cnt, 32'd3);
    chk("i_stall_cnt_model", i_stall_cnt, 32'(exp_icnt));
    chk("d_stall_cnt_model", d_stall_cnt, 32'(exp_dcnt));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
